instr_fetch: RTL and testbench

- Consumer side of the program counter.
- Each cycle it can, it samples PC, issues a read to instruction memory over a REQ/ACK handshake, and captures the returned 16-bit word into an instruction register.
- It presents the word to decode with a VALID/READY handshake and drives PC_EN to advance the PC.
- On a branch it takes FLUSH, which the branch unit asserts in the same cycle as PC_LD, discards in-flight work and refetches at the redirected PC.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default bus widths, fetch state encoding and the NOP word.
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 16;

  localparam logic [1:0] FETCH_IDLE  = 2'd0;
  localparam logic [1:0] FETCH_REQ   = 2'd1;
  localparam logic [1:0] FETCH_VALID = 2'd2;
  localparam logic [1:0] FETCH_REDIR = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = FETCH_IDLE,
    StReq   = FETCH_REQ,
    StValid = FETCH_VALID,
    StRedir = FETCH_REDIR
  } fetch_state_e;

  localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: reads imem at PC over REQ/ACK, holds the word in IR until decode takes it.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [ADDR_W-1:0]  pc,
  output logic               pc_en,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready
);

  fetch_state_e       state_q, state_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= INSTR_W'(NOP);
      ir_pc_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
    end
  end

  // A flushed ACK must not advance the PC: the branch unit is loading it this cycle.
  assign pc_en = (state_q == StReq) & imem_ack & ~flush;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;

    if (flush) begin
      state_d = StRedir;
      req_d   = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_d = StReq;
            req_d   = 1'b1;
            addr_d  = pc;
          end
        end
        StReq: begin
          if (imem_ack) begin
            state_d = StValid;
            req_d   = 1'b0;
            ir_d    = imem_data;
            ir_pc_d = addr_q;
            valid_d = 1'b1;
          end
        end
        StValid: begin
          if (valid_q && ir_ready) begin
            valid_d = 1'b0;
            if (run) begin
              state_d = StReq;
              req_d   = 1'b1;
              addr_d  = pc;
            end else begin
              state_d = StIdle;
            end
          end
        end
        StRedir: begin
          if (run) begin
            state_d = StReq;
            req_d   = 1'b1;
            addr_d  = pc;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: per-cycle vector table plus reset and halt sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, flush, imem_ack, ir_ready;
  logic [7:0]  pc;
  logic [15:0] imem_data;
  logic        pc_en, imem_req, ir_valid;
  logic [7:0]  imem_addr, ir_pc;
  logic [15:0] ir;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .pc        (pc),
    .pc_en     (pc_en),
    .flush     (flush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready)
  );

  typedef struct {
    logic        run, flush, ack, ready;
    logic [7:0]  pc;
    logic [15:0] data;
    logic        e_pcen, e_req;
    logic [7:0]  e_addr;
    logic [15:0] e_ir;
    logic [7:0]  e_irpc;
    logic        e_v;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic a, input logic rd,
                              input logic [7:0] p, input logic [15:0] d, input logic epe,
                              input logic erq, input logic [7:0] ead, input logic [15:0] eir,
                              input logic [7:0] eip, input logic ev);
    vec_t t;
    t.run = r; t.flush = f; t.ack = a; t.ready = rd; t.pc = p; t.data = d;
    t.e_pcen = epe; t.e_req = erq; t.e_addr = ead; t.e_ir = eir; t.e_irpc = eip; t.e_v = ev;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Apply inputs just after a rising edge; outputs are compared 1ns later.
  task automatic drive(input logic r, input logic f, input logic a, input logic rd,
                       input logic [7:0] p, input logic [15:0] d);
    @(posedge clk);
    #1;
    run = r; flush = f; imem_ack = a; ir_ready = rd; pc = p; imem_data = d;
    #1;
  endtask

  vec_t tbl[35];

  initial begin
    tbl[0]  = mk(1,0,0,1,8'h00,16'h0000, 0,0,8'h00,16'h0000,8'h00,0);
    tbl[1]  = mk(1,0,0,1,8'h00,16'h0000, 0,1,8'h00,16'h0000,8'h00,0);
    tbl[2]  = mk(1,0,1,1,8'h00,16'hA000, 1,1,8'h00,16'h0000,8'h00,0);
    tbl[3]  = mk(1,0,0,1,8'h01,16'h0000, 0,0,8'h00,16'hA000,8'h00,1);
    tbl[4]  = mk(1,0,0,1,8'h01,16'h0000, 0,1,8'h01,16'hA000,8'h00,0);
    tbl[5]  = mk(1,0,1,1,8'h01,16'hA001, 1,1,8'h01,16'hA000,8'h00,0);
    tbl[6]  = mk(1,0,0,1,8'h02,16'h0000, 0,0,8'h01,16'hA001,8'h01,1);
    tbl[7]  = mk(1,0,0,1,8'h02,16'h0000, 0,1,8'h02,16'hA001,8'h01,0);
    tbl[8]  = mk(1,0,1,1,8'h02,16'hA002, 1,1,8'h02,16'hA001,8'h01,0);
    tbl[9]  = mk(1,0,0,1,8'h03,16'h0000, 0,0,8'h02,16'hA002,8'h02,1);
    tbl[10] = mk(1,0,0,1,8'h03,16'h0000, 0,1,8'h03,16'hA002,8'h02,0);
    tbl[11] = mk(1,0,1,1,8'h03,16'hA003, 1,1,8'h03,16'hA002,8'h02,0);
    for (int i = 12; i < 17; i++)
      tbl[i] = mk(1,0,0,0,8'h04,16'h0000, 0,0,8'h03,16'hA003,8'h03,1);
    tbl[17] = mk(1,0,0,1,8'h04,16'h0000, 0,0,8'h03,16'hA003,8'h03,1);
    tbl[18] = mk(1,0,0,1,8'h04,16'h0000, 0,1,8'h04,16'hA003,8'h03,0);
    tbl[19] = mk(1,0,1,1,8'h04,16'hA004, 1,1,8'h04,16'hA003,8'h03,0);
    tbl[20] = mk(1,0,0,1,8'h05,16'h0000, 0,0,8'h04,16'hA004,8'h04,1);
    tbl[21] = mk(1,0,0,1,8'h05,16'h0000, 0,1,8'h05,16'hA004,8'h04,0);
    tbl[22] = mk(1,1,1,1,8'h05,16'hA005, 0,1,8'h05,16'hA004,8'h04,0);
    tbl[23] = mk(1,0,0,1,8'hCB,16'h0000, 0,0,8'h05,16'hA004,8'h04,0);
    tbl[24] = mk(1,0,0,1,8'hCB,16'h0000, 0,1,8'hCB,16'hA004,8'h04,0);
    tbl[25] = mk(1,0,1,1,8'hCB,16'hA0CB, 1,1,8'hCB,16'hA004,8'h04,0);
    tbl[26] = mk(1,1,0,1,8'hCC,16'h0000, 0,0,8'hCB,16'hA0CB,8'hCB,1);
    tbl[27] = mk(1,0,0,1,8'hFF,16'h0000, 0,0,8'hCB,16'hA0CB,8'hCB,0);
    tbl[28] = mk(1,0,0,1,8'hFF,16'h0000, 0,1,8'hFF,16'hA0CB,8'hCB,0);
    tbl[29] = mk(1,0,1,1,8'hFF,16'hA0FF, 1,1,8'hFF,16'hA0CB,8'hCB,0);
    tbl[30] = mk(1,0,0,1,8'h00,16'h0000, 0,0,8'hFF,16'hA0FF,8'hFF,1);
    tbl[31] = mk(1,0,0,1,8'h00,16'h0000, 0,1,8'h00,16'hA0FF,8'hFF,0);
    tbl[32] = mk(1,0,1,1,8'h00,16'hB000, 1,1,8'h00,16'hA0FF,8'hFF,0);
    tbl[33] = mk(0,0,0,1,8'h01,16'h0000, 0,0,8'h00,16'hB000,8'h00,1);
    tbl[34] = mk(0,0,0,1,8'h01,16'h0000, 0,0,8'h00,16'hB000,8'h00,0);

    rst_n = 1'b0; run = 0; flush = 0; imem_ack = 0; ir_ready = 0; pc = 8'h00; imem_data = '0;
    #2;
    chk("reset imem_req", 32'(imem_req), 32'h0);
    chk("reset imem_addr", 32'(imem_addr), 32'h0);
    chk("reset ir", 32'(ir), 32'h0);
    chk("reset ir_pc", 32'(ir_pc), 32'h0);
    chk("reset ir_valid", 32'(ir_valid), 32'h0);
    chk("reset pc_en", 32'(pc_en), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Streaming, decode stall, branch during REQ, branch in VALID, wrap, halt from VALID
    for (int i = 0; i < 35; i++) begin
      drive(tbl[i].run, tbl[i].flush, tbl[i].ack, tbl[i].ready, tbl[i].pc, tbl[i].data);
      chk($sformatf("row%0d pc_en", i), 32'(pc_en), 32'(tbl[i].e_pcen));
      chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("row%0d imem_addr", i), 32'(imem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d ir", i), 32'(ir), 32'(tbl[i].e_ir));
      chk($sformatf("row%0d ir_pc", i), 32'(ir_pc), 32'(tbl[i].e_irpc));
      chk($sformatf("row%0d ir_valid", i), 32'(ir_valid), 32'(tbl[i].e_v));
    end

    // Halt: RUN drops while the 0x29 fetch is outstanding
    drive(1, 0, 0, 1, 8'h29, 16'h0000);
    chk("halt idle req", 32'(imem_req), 32'h0);
    drive(0, 0, 0, 1, 8'h29, 16'h0000);
    chk("halt req", 32'(imem_req), 32'h1);
    chk("halt addr", 32'(imem_addr), 32'h29);
    drive(0, 0, 1, 1, 8'h29, 16'hA029);
    chk("halt pc_en", 32'(pc_en), 32'h1);
    drive(0, 0, 0, 1, 8'h2A, 16'h0000);
    chk("halt ir", 32'(ir), 32'hA029);
    chk("halt ir_pc", 32'(ir_pc), 32'h29);
    chk("halt ir_valid", 32'(ir_valid), 32'h1);
    chk("halt req drop", 32'(imem_req), 32'h0);
    drive(0, 0, 0, 1, 8'h2A, 16'h0000);
    chk("halt stopped valid", 32'(ir_valid), 32'h0);
    chk("halt stopped req", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 1, 8'h2A, 16'h0000);
    chk("halt still idle", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 1, 8'h2A, 16'h0000);
    chk("resume req", 32'(imem_req), 32'h1);
    chk("resume addr", 32'(imem_addr), 32'h2A);

    // Asynchronous reset with a request outstanding and ACK high
    drive(1, 0, 1, 1, 8'h10, 16'hDEAD);
    chk("pre-reset pc_en", 32'(pc_en), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async rst imem_req", 32'(imem_req), 32'h0);
    chk("async rst ir_valid", 32'(ir_valid), 32'h0);
    chk("async rst pc_en", 32'(pc_en), 32'h0);
    chk("async rst ir", 32'(ir), 32'h0);
    run = 0; imem_ack = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 0, 0, 1, 8'h10, 16'h0000);
    chk("post rst req", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 1, 8'h10, 16'h0000);
    chk("post rst idle", 32'(imem_req), 32'h0);
    drive(1, 0, 0, 1, 8'h10, 16'h0000);
    chk("post rst fetch req", 32'(imem_req), 32'h1);
    chk("post rst fetch addr", 32'(imem_addr), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
